// File: rtl/jt12_opram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jt12_opram_pkg
// Brief    : Shared constants and types for the operator-parameter RAM
//            write sequencer: word field positions, register groups,
//            operator reorder table, FSM states and pending-write entry.
// Revision : 1.0 - initial release
// ============================================================================
package jt12_opram_pkg;

  // Sweep geometry
  localparam int c_NSLOT  = 24;
  localparam int c_AW     = 5;
  localparam int c_WORD_W = 44;

  // Field bit positions inside a 44-bit operator word
  localparam int c_DT_HI  = 43;
  localparam int c_DT_LO  = 41;
  localparam int c_MUL_HI = 40;
  localparam int c_MUL_LO = 37;
  localparam int c_TL_HI  = 36;
  localparam int c_TL_LO  = 30;
  localparam int c_KS_HI  = 29;
  localparam int c_KS_LO  = 28;
  localparam int c_AR_HI  = 27;
  localparam int c_AR_LO  = 23;
  localparam int c_AM_BIT = 22;
  localparam int c_D1R_HI = 21;
  localparam int c_D1R_LO = 17;
  localparam int c_D2R_HI = 16;
  localparam int c_D2R_LO = 12;
  localparam int c_SL_HI  = 11;
  localparam int c_SL_LO  = 8;
  localparam int c_RR_HI  = 7;
  localparam int c_RR_LO  = 4;
  localparam int c_SSG_HI = 3;
  localparam int c_SSG_LO = 0;

  // Register groups (upper nibble of the register address)
  localparam logic [3:0] c_GRP_DT_MUL = 4'd3;
  localparam logic [3:0] c_GRP_TL     = 4'd4;
  localparam logic [3:0] c_GRP_KS_AR  = 4'd5;
  localparam logic [3:0] c_GRP_AM_D1R = 4'd6;
  localparam logic [3:0] c_GRP_D2R    = 4'd7;
  localparam logic [3:0] c_GRP_SL_RR  = 4'd8;
  localparam logic [3:0] c_GRP_SSG    = 4'd9;

  // Register address bits [3:2] enumerate operators as 1,3,2,4
  localparam logic [1:0] c_OP_REORDER [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Single outstanding CPU write waiting for its slot to come round
  typedef struct packed {
    logic [c_AW-1:0] slot;
    logic [3:0]      group;
    logic [7:0]      din;
    logic            valid;
  } pend_t;

endpackage
`default_nettype wire

// File: rtl/jt12_opram_merge.sv
`default_nettype none
// ============================================================================
// Module   : jt12_opram_merge
// Brief    : Combinational field merge: replaces the fields selected by a
//            register group with bits of the register data, keeping the
//            rest of the operator word.
// Revision : 1.0 - initial release
// ============================================================================
module jt12_opram_merge
  import jt12_opram_pkg::*;
(
  input  logic [c_WORD_W-1:0] i_word,
  input  logic [3:0]          i_group,
  input  logic [7:0]          i_din,
  output logic [c_WORD_W-1:0] o_word
);

  // Overwrite only the fields owned by the addressed register group
  always_comb begin
    o_word = i_word;
    case (i_group)
      c_GRP_DT_MUL: begin
        o_word[c_DT_HI:c_DT_LO]   = i_din[6:4];
        o_word[c_MUL_HI:c_MUL_LO] = i_din[3:0];
      end
      c_GRP_TL: begin
        o_word[c_TL_HI:c_TL_LO]   = i_din[6:0];
      end
      c_GRP_KS_AR: begin
        o_word[c_KS_HI:c_KS_LO]   = i_din[7:6];
        o_word[c_AR_HI:c_AR_LO]   = i_din[4:0];
      end
      c_GRP_AM_D1R: begin
        o_word[c_AM_BIT]          = i_din[7];
        o_word[c_D1R_HI:c_D1R_LO] = i_din[4:0];
      end
      c_GRP_D2R: begin
        o_word[c_D2R_HI:c_D2R_LO] = i_din[4:0];
      end
      c_GRP_SL_RR: begin
        o_word[c_SL_HI:c_SL_LO]   = i_din[7:4];
        o_word[c_RR_HI:c_RR_LO]   = i_din[3:0];
      end
      c_GRP_SSG: begin
        o_word[c_SSG_HI:c_SSG_LO] = i_din[3:0];
      end
      default: o_word = i_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/jt12_opram_wr.sv
`default_nettype none
// ============================================================================
// Module   : jt12_opram_wr
// Brief    : Sequencer for the 32x44 operator-parameter RAM. Clears the RAM
//            after reset, then sweeps the live slots writing each word back,
//            merging one pending CPU register write into its target slot.
// Revision : 1.0 - initial release
// ============================================================================
module jt12_opram_wr
  import jt12_opram_pkg::*;
#(
  parameter int NSLOT = c_NSLOT,
  parameter int AW    = c_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                cpu_we,
  input  logic                cpu_part,
  input  logic [7:0]          cpu_addr,
  input  logic [7:0]          cpu_din,
  input  logic [c_WORD_W-1:0] ram_q,
  output logic [AW-1:0]       rd_addr,
  output logic [AW-1:0]       wr_addr,
  output logic [c_WORD_W-1:0] ram_din,
  output logic                busy,
  output logic                wr_drop
);

  state_t              r_state, w_state_nxt;
  // r_wr_addr doubles as the clear counter during INIT and the
  // write-back slot during RUN; r_rd_addr is the read slot.
  logic [AW-1:0]       r_rd_addr, w_rd_nxt;
  logic [AW-1:0]       r_wr_addr, w_wr_nxt;
  pend_t               r_pend;
  logic                r_wr_drop;

  logic [3:0]          w_group;
  logic [1:0]          w_op;
  logic [2:0]          w_ch;
  logic [AW-1:0]       w_slot;
  logic                w_valid_addr;
  logic                w_hit;
  logic [c_WORD_W-1:0] w_merged;

  // Decode the CPU register address into group, slot and validity
  always_comb begin
    w_group      = cpu_addr[7:4];
    w_op         = c_OP_REORDER[cpu_addr[3:2]];
    w_ch         = (cpu_part ? 3'd3 : 3'd0) + {1'b0, cpu_addr[1:0]};
    w_slot       = AW'(int'(w_op) * 6 + int'(w_ch));
    w_valid_addr = (w_group >= c_GRP_DT_MUL) && (w_group <= c_GRP_SSG) &&
                   (cpu_addr[1:0] != 2'd3);
  end

  // State, read slot and write slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_addr <= w_rd_nxt;
      r_wr_addr <= w_wr_nxt;
    end
  end

  // Next-state: clear all 32 entries, then sweep live slots with the
  // write slot trailing the read slot by one (registered RAM read)
  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = r_rd_addr;
    w_wr_nxt    = r_wr_addr;
    if (clk_en) begin
      case (r_state)
        ST_INIT: begin
          if (r_wr_addr == {AW{1'b1}}) begin
            w_state_nxt = ST_RUN;
            w_rd_nxt    = AW'(1);
            w_wr_nxt    = '0;
          end else begin
            w_wr_nxt    = r_wr_addr + AW'(1);
          end
        end
        ST_RUN: begin
          w_wr_nxt = r_rd_addr;
          w_rd_nxt = (r_rd_addr == AW'(NSLOT - 1)) ? '0 : r_rd_addr + AW'(1);
        end
        default: w_state_nxt = ST_INIT;
      endcase
    end
  end

  // Merge only from the registered entry, so a capture never races the
  // slot currently being written back
  assign w_hit = (r_state == ST_RUN) && r_pend.valid && (r_pend.slot == r_wr_addr);

  jt12_opram_merge u_merge (
    .i_word  (ram_q),
    .i_group (r_pend.group),
    .i_din   (r_pend.din),
    .o_word  (w_merged)
  );

  // Pending-write capture (every clk) and retirement (on the merging clk_en)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_wr_drop <= cpu_we && w_valid_addr && busy;
      if (cpu_we && w_valid_addr && !busy) begin
        r_pend <= '{slot: w_slot, group: w_group, din: cpu_din, valid: 1'b1};
      end else if (clk_en && w_hit) begin
        r_pend.valid <= 1'b0;
      end
    end
  end

  // RAM write data: zeros while clearing, else read-back with optional merge
  always_comb begin
    ram_din = '0;
    if (r_state == ST_RUN) begin
      ram_din = w_hit ? w_merged : ram_q;
    end
  end

  assign rd_addr = r_rd_addr;
  assign wr_addr = r_wr_addr;
  assign busy    = (r_state == ST_INIT) || r_pend.valid;
  assign wr_drop = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_jt12_opram_wr.sv
`default_nettype none
// ============================================================================
// Module   : tb_jt12_opram_wr
// Brief    : Self-checking bench for jt12_opram_wr with a registered-read
//            RAM model, a shadow copy of expected contents and a queue of
//            expected write-backs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jt12_opram_wr;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, cpu_we, cpu_part;
  logic [7:0]  cpu_addr, cpu_din;
  logic [43:0] ram_q;
  logic [4:0]  rd_addr, wr_addr;
  logic [43:0] ram_din;
  logic        busy, wr_drop;

  typedef struct {
    int          addr;
    logic [43:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [43:0] mem    [0:31];
  logic [43:0] shadow [0:23];
  int          total = 0;
  int          bad   = 0;

  jt12_opram_wr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_en   (clk_en),
    .cpu_we   (cpu_we),
    .cpu_part (cpu_part),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .ram_q    (ram_q),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .ram_din  (ram_din),
    .busy     (busy),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  // Registered-read RAM with no write enable: writes every clk_en
  always @(posedge clk) begin
    if (clk_en) begin
      ram_q        <= mem[rd_addr];
      mem[wr_addr] <= ram_din;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent mask-based view of the register field layout
  function automatic logic [43:0] ref_merge(input logic [43:0] w, input logic [3:0] g,
                                            input logic [7:0] d);
    logic [43:0] m, v;
    m = '0; v = '0;
    case (g)
      4'd3: begin m = 44'h7F << 37; v = {37'd0, d[6:0]} << 37; end
      4'd4: begin m = 44'h7F << 30; v = {37'd0, d[6:0]} << 30; end
      4'd5: begin m = (44'h3 << 28) | (44'h1F << 23);
                  v = ({42'd0, d[7:6]} << 28) | ({39'd0, d[4:0]} << 23); end
      4'd6: begin m = (44'h1 << 22) | (44'h1F << 17);
                  v = ({43'd0, d[7]} << 22) | ({39'd0, d[4:0]} << 17); end
      4'd7: begin m = 44'h1F << 12; v = {39'd0, d[4:0]} << 12; end
      4'd8: begin m = 44'hFF << 4;  v = {36'd0, d} << 4; end
      4'd9: begin m = 44'hF;        v = {40'd0, d[3:0]}; end
      default: ;
    endcase
    return (w & ~m) | (v & m);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b0; cpu_we = 1'b0; cpu_part = 1'b0;
    cpu_addr = 8'h00; cpu_din = 8'h00;
    for (int k = 0; k < 32; k++) mem[k] = 44'hABC_DEAD_BEEF;
    repeat (3) tick();
    total++; if (rd_addr !== 5'd0) begin bad++; $display("FAIL rst_rd_addr got=%0h want=0", rd_addr); end
    total++; if (wr_addr !== 5'd0) begin bad++; $display("FAIL rst_wr_addr got=%0h want=0", wr_addr); end
    total++; if (ram_din !== 44'd0) begin bad++; $display("FAIL rst_ram_din got=%0h want=0", ram_din); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%0b want=1", busy); end
    total++; if (wr_drop !== 1'b0) begin bad++; $display("FAIL rst_wr_drop got=%0b want=0", wr_drop); end
    rst_n = 1'b1; clk_en = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back('{i, 44'd0});
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      total++; if (wr_addr !== 5'(e.addr) || ram_din !== e.data || rd_addr !== 5'd0 || busy !== 1'b1) begin
        bad++; $display("FAIL init_step got wr=%0d din=%0h rd=%0d busy=%0b want wr=%0d din=%0h rd=0 busy=1",
                        wr_addr, ram_din, rd_addr, busy, e.addr, e.data);
      end
      tick();
    end
    total++; if (busy !== 1'b0 || rd_addr !== 5'd1 || wr_addr !== 5'd0) begin
      bad++; $display("FAIL init_exit got busy=%0b rd=%0d wr=%0d want busy=0 rd=1 wr=0", busy, rd_addr, wr_addr);
    end
    for (int k = 0; k < 32; k++) begin
      total++; if (mem[k] !== 44'd0) begin bad++; $display("FAIL init_clear[%0d] got=%0h want=0", k, mem[k]); end
    end
  endtask

  task automatic test_idle_sweep();
    // Preload between edges; slot 0 is already being written back
    for (int k = 0; k < 24; k++) begin
      shadow[k] = 44'(k * 3);
      if (k != 0) mem[k] = 44'(k * 3);
    end
    for (int i = 0; i < 48; i++) exp_q.push_back('{i % 24, shadow[i % 24]});
    for (int i = 0; i < 48; i++) begin
      e = exp_q.pop_front();
      total++; if (wr_addr !== 5'(e.addr) || ram_din !== e.data || rd_addr !== 5'((e.addr + 1) % 24)) begin
        bad++; $display("FAIL idle_wb got wr=%0d rd=%0d din=%0h want wr=%0d rd=%0d din=%0h",
                        wr_addr, rd_addr, ram_din, e.addr, (e.addr + 1) % 24, e.data);
      end
      tick();
    end
  endtask

  task automatic test_fields();
    logic [7:0] t_addr [7] = '{8'h42, 8'h34, 8'h51, 8'h7E, 8'h89, 8'h9D, 8'h66};
    logic       t_part [7] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
    logic [7:0] t_din  [7] = '{8'h7F, 8'h5A, 8'hDF, 8'hF5, 8'hA6, 8'hFC, 8'h95};
    int         t_slot [7] = '{5, 12, 1, 23, 7, 22, 17};
    bit         landed;
    for (int c = 0; c < 30 && wr_addr != 5'd0; c++) tick();
    total++; if (wr_addr !== 5'd0) begin bad++; $display("FAIL align0 got=%0d want=0", wr_addr); end
    mem[12] = 44'd0; shadow[12] = 44'd0;
    for (int t = 0; t < 7; t++) begin
      cpu_part = t_part[t]; cpu_addr = t_addr[t]; cpu_din = t_din[t]; cpu_we = 1'b1;
      tick();
      cpu_we = 1'b0;
      exp_q.push_back('{t_slot[t], ref_merge(shadow[t_slot[t]], t_addr[t][7:4], t_din[t])});
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL capture_busy[%0h] got=%0b want=1", t_addr[t], busy); end
      landed = 1'b0;
      for (int c = 0; c < 26 && !landed; c++) begin
        if (wr_addr == 5'(exp_q[0].addr)) begin
          e = exp_q.pop_front();
          total++; if (ram_din !== e.data) begin
            bad++; $display("FAIL merge[%0h] slot=%0d got=%0h want=%0h", t_addr[t], e.addr, ram_din, e.data);
          end
          shadow[e.addr] = e.data; landed = 1'b1;
          tick();
          total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_clear[%0h] got=%0b want=0", t_addr[t], busy); end
        end else begin
          total++; if (wr_addr > 5'd23 || ram_din !== shadow[wr_addr]) begin
            bad++; $display("FAIL passthru wr=%0d got=%0h", wr_addr, ram_din);
          end
          tick();
        end
      end
      if (!landed) begin
        total++; bad++; $display("FAIL land_timeout[%0h] got=none want=slot %0d", t_addr[t], t_slot[t]);
        exp_q.delete();
      end
    end
  endtask

  task automatic test_drop_invalid();
    bit landed;
    for (int c = 0; c < 30 && wr_addr != 5'd5; c++) tick();
    total++; if (wr_addr !== 5'd5) begin bad++; $display("FAIL align5 got=%0d want=5", wr_addr); end
    cpu_part = 1'b0; cpu_addr = 8'h60; cpu_din = 8'h9F; cpu_we = 1'b1;
    tick();
    exp_q.push_back('{0, ref_merge(shadow[0], 4'd6, 8'h9F)});
    cpu_part = 1'b1; cpu_addr = 8'h70; cpu_din = 8'h15;
    tick();
    cpu_we = 1'b0;
    total++; if (wr_drop !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL drop_pulse got drop=%0b busy=%0b want drop=1 busy=1", wr_drop, busy);
    end
    tick();
    total++; if (wr_drop !== 1'b0) begin bad++; $display("FAIL drop_width got=%0b want=0", wr_drop); end
    cpu_addr = 8'hA0; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    total++; if (wr_drop !== 1'b0) begin bad++; $display("FAIL invalid_busy_drop got=%0b want=0", wr_drop); end
    landed = 1'b0;
    for (int c = 0; c < 26 && !landed; c++) begin
      if (wr_addr == 5'd0) begin
        e = exp_q.pop_front();
        total++; if (ram_din !== e.data) begin bad++; $display("FAIL drop_first_lands got=%0h want=%0h", ram_din, e.data); end
        shadow[0] = e.data; landed = 1'b1;
      end
      tick();
    end
    if (!landed) begin total++; bad++; $display("FAIL drop_timeout got=none want=slot 0"); exp_q.delete(); end
    cpu_part = 1'b0; cpu_addr = 8'h33; cpu_din = 8'h77; cpu_we = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || wr_drop !== 1'b0) begin
      bad++; $display("FAIL ignore_33 got busy=%0b drop=%0b want 0 0", busy, wr_drop);
    end
    cpu_addr = 8'hA0;
    tick();
    cpu_we = 1'b0;
    total++; if (busy !== 1'b0 || wr_drop !== 1'b0) begin
      bad++; $display("FAIL ignore_A0 got busy=%0b drop=%0b want 0 0", busy, wr_drop);
    end
  endtask

  task automatic test_freeze();
    for (int c = 0; c < 30 && wr_addr != 5'd7; c++) tick();
    total++; if (wr_addr !== 5'd7) begin bad++; $display("FAIL align7 got=%0d want=7", wr_addr); end
    clk_en = 1'b0;
    cpu_part = 1'b0; cpu_addr = 8'h8A; cpu_din = 8'hC3; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    exp_q.push_back('{8, ref_merge(shadow[8], 4'd8, 8'hC3)});
    for (int i = 0; i < 10; i++) begin
      total++; if (wr_addr !== 5'd7 || rd_addr !== 5'd8 || ram_din !== shadow[7] || busy !== 1'b1) begin
        bad++; $display("FAIL freeze[%0d] got wr=%0d rd=%0d din=%0h busy=%0b want wr=7 rd=8 din=%0h busy=1",
                        i, wr_addr, rd_addr, ram_din, busy, shadow[7]);
      end
      if (i < 9) tick();
    end
    clk_en = 1'b1;
    tick();
    e = exp_q.pop_front();
    total++; if (wr_addr !== 5'(e.addr) || ram_din !== e.data) begin
      bad++; $display("FAIL thaw_merge got wr=%0d din=%0h want wr=%0d din=%0h", wr_addr, ram_din, e.addr, e.data);
    end
    shadow[e.addr] = e.data;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL thaw_busy got=%0b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 30 && wr_addr != 5'd10; c++) tick();
    cpu_part = 1'b0; cpu_addr = 8'h42; cpu_din = 8'h11; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_capture got=%0b want=1", busy); end
    rst_n = 1'b0;
    #2;
    total++; if (wr_addr !== 5'd0 || rd_addr !== 5'd0 || ram_din !== 44'd0 || busy !== 1'b1 || wr_drop !== 1'b0) begin
      bad++; $display("FAIL async_rst got wr=%0d rd=%0d din=%0h busy=%0b drop=%0b want 0 0 0 1 0",
                      wr_addr, rd_addr, ram_din, busy, wr_drop);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back('{i, 44'd0});
    for (int i = 0; i < 32; i++) begin
      e = exp_q.pop_front();
      total++; if (wr_addr !== 5'(e.addr) || ram_din !== e.data) begin
        bad++; $display("FAIL reinit got wr=%0d din=%0h want wr=%0d din=0", wr_addr, ram_din, e.addr);
      end
      tick();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pend_lost got busy=%0b want=0", busy); end
    for (int i = 0; i < 24; i++) begin
      total++; if (wr_addr !== 5'(i) || ram_din !== 44'd0) begin
        bad++; $display("FAIL post_rst_sweep got wr=%0d din=%0h want wr=%0d din=0", wr_addr, ram_din, i);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_idle_sweep();
    test_fields();
    test_drop_invalid();
    test_freeze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
